fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the combinational instruction memory. It drives the program counter onto the memory's address input and captures the returned 16-bit instruction into a fetch/decode register. It also performs its own redirection: it predecodes JUMP in the fetch register, applies taken-BNE redirects from execute, and enters the interrupt vector on IRQ. All redirects squash the wrong-path fetch.

---
 rtl/fetch_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with JUMP predecode, BNE redirect and optional IRQ entry
// Optional interrupt support (IRQ/IRET, IRQ_SVC state, EPC) is built when FETCH_IRQ_EN is defined.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] IRQ_VEC  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [15:0] br_pc,
   input  logic [3:0]  br_imm,
   input  logic        iret,
   input  logic        irq,
   input  logic [15:0] instr_in,
   output logic [15:0] pc,
   output logic [15:0] ir_out,
   output logic [15:0] ir_pc,
   output logic        ir_valid,
   output logic        irq_ack,
   output logic [15:0] epc
);

   logic [15:0] br_target;
   logic [15:0] jump_target;
   logic        jump_hit;
   logic        iret_take;
   logic        irq_take;

   assign br_target   = br_pc + 16'd1 + {{12{br_imm[3]}}, br_imm};
   assign jump_target = {ir_pc[15:12], ir_out[11:0]};
   assign jump_hit    = ir_valid && (ir_out[15:12] == 4'hF) && !stall;

`ifdef FETCH_IRQ_EN
   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_IRQ_SVC = 1'b1;

   logic [0:0] state;
   logic       enter_irq;
   logic       leave_irq;

   assign iret_take = iret && (state == ST_IRQ_SVC);
   assign irq_take  = irq && (state == ST_RUN) && !stall;

   // Entry/exit only happen when that case actually wins the next-PC priority.
   assign enter_irq = irq_take && !br_taken && !iret_take && !jump_hit;
   assign leave_irq = iret_take && !br_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         epc     <= 16'h0000;
         irq_ack <= 1'b0;
      end else begin
         irq_ack <= enter_irq;
         if (enter_irq) begin
            state <= ST_IRQ_SVC;
            epc   <= pc;
         end else if (leave_irq) begin
            state <= ST_RUN;
         end
      end
   end
`else
   logic unused_irq_inputs;

   assign unused_irq_inputs = irq ^ iret;
   assign iret_take         = 1'b0;
   assign irq_take          = 1'b0;
   assign irq_ack           = 1'b0;
   assign epc               = 16'h0000;
`endif

   // Every redirect squashes the fetch on instr_in; ir_out/ir_pc keep their last values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         ir_out   <= 16'h0000;
         ir_pc    <= 16'h0000;
         ir_valid <= 1'b0;
      end else if (br_taken) begin
         pc       <= br_target;
         ir_valid <= 1'b0;
      end else if (iret_take) begin
         pc       <= epc;
         ir_valid <= 1'b0;
      end else if (jump_hit) begin
         pc       <= jump_target;
         ir_valid <= 1'b0;
      end else if (irq_take) begin
         pc       <= IRQ_VEC;
         ir_valid <= 1'b0;
      end else if (!stall) begin
         ir_out   <= instr_in;
         ir_pc    <= pc;
         ir_valid <= 1'b1;
         pc       <= pc + 16'd1;
      end
   end

endmodule
